control_pipe: RTL and testbench

//  Parametrised successor of the ID-stage control decoder. Decodes the 6-bit opcode into DE/EX/M/WB

---
 rtl/ctrl_pkg.sv | 43 ++++
 rtl/ctrl_decode.sv | 45 ++++
 rtl/control_pipe.sv | 154 +++++++++++++++
 tb/tb_control_pipe.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// ctrl_pkg: opcode encodings, control-group widths, decode-table constants
// and the bubble constant shared by the decoder and the control pipeline.
package ctrl_pkg;

  localparam int PKG_OP_W = 6;
  localparam int PKG_EX_W = 4;
  localparam int PKG_M_W  = 2;
  localparam int PKG_WB_W = 2;
  localparam int PKG_DE_W = 2;

  // Opcodes recognised by the decoder
  localparam logic [PKG_OP_W-1:0] OP_R    = 6'b000000;
  localparam logic [PKG_OP_W-1:0] OP_J    = 6'b000010;
  localparam logic [PKG_OP_W-1:0] OP_JAL  = 6'b000011;
  localparam logic [PKG_OP_W-1:0] OP_BEQ  = 6'b000100;
  localparam logic [PKG_OP_W-1:0] OP_BNE  = 6'b000101;
  localparam logic [PKG_OP_W-1:0] OP_ADDI = 6'b001000;
  localparam logic [PKG_OP_W-1:0] OP_SLTI = 6'b001010;
  localparam logic [PKG_OP_W-1:0] OP_ANDI = 6'b001100;
  localparam logic [PKG_OP_W-1:0] OP_ORI  = 6'b001101;
  localparam logic [PKG_OP_W-1:0] OP_XORI = 6'b001110;
  localparam logic [PKG_OP_W-1:0] OP_LW   = 6'b100011;
  localparam logic [PKG_OP_W-1:0] OP_SW   = 6'b101011;

  // One decoded instruction: DE is used in ID, the rest ride the pipeline
  typedef struct packed {
    logic [PKG_DE_W-1:0] de;
    logic [PKG_EX_W-1:0] ex;
    logic [PKG_M_W-1:0]  m;
    logic [PKG_WB_W-1:0] wb;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;
  localparam ctrl_t CTRL_LW     = '{de: 2'b00, ex: 4'b0100, m: 2'b10, wb: 2'b10};
  localparam ctrl_t CTRL_SW     = '{de: 2'b00, ex: 4'b0100, m: 2'b01, wb: 2'b00};
  localparam ctrl_t CTRL_BEQ    = '{de: 2'b11, ex: 4'b0001, m: 2'b00, wb: 2'b00};
  localparam ctrl_t CTRL_BNE    = '{de: 2'b10, ex: 4'b0001, m: 2'b00, wb: 2'b00};
  localparam ctrl_t CTRL_R      = '{de: 2'b00, ex: 4'b1010, m: 2'b00, wb: 2'b11};
  localparam ctrl_t CTRL_IMM    = '{de: 2'b00, ex: 4'b1110, m: 2'b00, wb: 2'b11};
  localparam ctrl_t CTRL_J      = '{de: 2'b01, ex: 4'b0000, m: 2'b00, wb: 2'b00};
  localparam ctrl_t CTRL_JAL    = '{de: 2'b01, ex: 4'b0000, m: 2'b00, wb: 2'b10};

endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode: pure combinational opcode -> {DE,EX,M,WB} plus illegal flag.
// Optional feature macro: CTRL_JUMP_EN (adds J/JAL decode; otherwise they are illegal).
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [PKG_OP_W-1:0] opcode_i,
  input  logic                valid_i,
  output ctrl_t               ctrl_o,
  output logic                illegal_o
);

  ctrl_t w_ctrl;
  logic  w_illegal;

  // Table lookup; unknown opcodes give all-zero control and raise illegal
  always_comb begin
    w_ctrl    = CTRL_BUBBLE;
    w_illegal = 1'b0;
    case (opcode_i)
      OP_LW:   w_ctrl = CTRL_LW;
      OP_SW:   w_ctrl = CTRL_SW;
      OP_BEQ:  w_ctrl = CTRL_BEQ;
      OP_BNE:  w_ctrl = CTRL_BNE;
      OP_R:    w_ctrl = CTRL_R;
      OP_ADDI, OP_ANDI, OP_SLTI, OP_ORI, OP_XORI:
               w_ctrl = CTRL_IMM;
`ifdef CTRL_JUMP_EN
      OP_J:    w_ctrl = CTRL_J;
      OP_JAL:  w_ctrl = CTRL_JAL;
`endif
      default: w_illegal = 1'b1;
    endcase
  end

  // A bubble in ID decodes to nothing and is never illegal
  always_comb begin
    ctrl_o    = CTRL_BUBBLE;
    illegal_o = 1'b0;
    if (valid_i) begin
      ctrl_o    = w_ctrl;
      illegal_o = w_illegal;
    end
  end

endmodule

// File: rtl/control_pipe.sv
// control_pipe: ID-stage control decode carried through ID/EX, EX/MEM and
// MEM/WB, with stall/flush bubbles, global hold (with pending flush), and
// illegal-opcode pulse plus saturating counter.
// Optional feature macro: CTRL_JUMP_EN (handled inside ctrl_decode).
module control_pipe
  import ctrl_pkg::*;
#(
  parameter int OP_W  = PKG_OP_W,
  parameter int EX_W  = PKG_EX_W,
  parameter int M_W   = PKG_M_W,
  parameter int WB_W  = PKG_WB_W,
  parameter int DE_W  = PKG_DE_W,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [OP_W-1:0]  opcode_i,
  input  logic             valid_i,
  input  logic             stall_i,
  input  logic             flush_i,
  input  logic             hold_i,
  output logic [DE_W-1:0]  de_ctrl_o,
  output logic [EX_W-1:0]  ex_ctrl_o,
  output logic [M_W-1:0]   m_ctrl_o,
  output logic [WB_W-1:0]  wb_ctrl_o,
  output logic             vld_ex_o,
  output logic             vld_mem_o,
  output logic             vld_wb_o,
  output logic             illegal_o,
  output logic [CNT_W-1:0] illegal_cnt_o
);

  ctrl_t w_dec;
  logic  w_dec_illegal;
  logic  w_bubble;
  logic  w_accept;

  // ID/EX
  logic [EX_W-1:0]  r_idex_ex;
  logic [M_W-1:0]   r_idex_m;
  logic [WB_W-1:0]  r_idex_wb;
  logic             r_idex_vld;
  // EX/MEM
  logic [M_W-1:0]   r_exmem_m;
  logic [WB_W-1:0]  r_exmem_wb;
  logic             r_exmem_vld;
  // MEM/WB
  logic [WB_W-1:0]  r_memwb_wb;
  logic             r_memwb_vld;

  logic             r_flush_pend;
  logic             r_illegal;
  logic [CNT_W-1:0] r_illegal_cnt;

  ctrl_decode u_decode (
    .opcode_i  (opcode_i),
    .valid_i   (valid_i),
    .ctrl_o    (w_dec),
    .illegal_o (w_dec_illegal)
  );

  // A pending flush from a hold period squashes the first advancing instruction
  assign w_bubble = stall_i | flush_i | r_flush_pend | ~valid_i;
  assign w_accept = ~hold_i & ~w_bubble;

  assign de_ctrl_o = w_dec.de;

  // ID/EX register: decode or bubble on advance, frozen on hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idex_ex  <= '0;
      r_idex_m   <= '0;
      r_idex_wb  <= '0;
      r_idex_vld <= 1'b0;
    end else if (!hold_i) begin
      if (w_bubble) begin
        r_idex_ex  <= CTRL_BUBBLE.ex;
        r_idex_m   <= CTRL_BUBBLE.m;
        r_idex_wb  <= CTRL_BUBBLE.wb;
        r_idex_vld <= 1'b0;
      end else begin
        r_idex_ex  <= w_dec.ex;
        r_idex_m   <= w_dec.m;
        r_idex_wb  <= w_dec.wb;
        r_idex_vld <= 1'b1;
      end
    end
  end

  // EX/MEM register: shift down M and WB groups
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_exmem_m   <= '0;
      r_exmem_wb  <= '0;
      r_exmem_vld <= 1'b0;
    end else if (!hold_i) begin
      r_exmem_m   <= r_idex_m;
      r_exmem_wb  <= r_idex_wb;
      r_exmem_vld <= r_idex_vld;
    end
  end

  // MEM/WB register: shift down WB group
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_memwb_wb  <= '0;
      r_memwb_vld <= 1'b0;
    end else if (!hold_i) begin
      r_memwb_wb  <= r_exmem_wb;
      r_memwb_vld <= r_exmem_vld;
    end
  end

  // Remember a flush that arrived while frozen; consumed by the first advance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flush_pend <= 1'b0;
    end else if (hold_i) begin
      if (flush_i) r_flush_pend <= 1'b1;
    end else begin
      r_flush_pend <= 1'b0;
    end
  end

  // Illegal pulse source; cleared on hold so no stale pulse reappears afterwards
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_illegal <= 1'b0;
    end else if (hold_i) begin
      r_illegal <= 1'b0;
    end else begin
      r_illegal <= w_accept & w_dec_illegal;
    end
  end

  // Saturating count of illegal opcodes accepted into ID/EX
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_illegal_cnt <= '0;
    end else if (w_accept && w_dec_illegal && (r_illegal_cnt != {CNT_W{1'b1}})) begin
      r_illegal_cnt <= r_illegal_cnt + 1'b1;
    end
  end

  assign ex_ctrl_o     = r_idex_ex;
  assign m_ctrl_o      = r_exmem_m;
  assign wb_ctrl_o     = r_memwb_wb;
  assign vld_ex_o      = r_idex_vld;
  assign vld_mem_o     = r_exmem_vld;
  assign vld_wb_o      = r_memwb_vld;
  assign illegal_o     = r_illegal & ~hold_i;
  assign illegal_cnt_o = r_illegal_cnt;

endmodule

// File: tb/tb_control_pipe.sv
// Testbench for control_pipe: instruction-token model plus directed vectors.
module tb_control_pipe;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] opcode = '0;
  logic       valid_i = 1'b0, stall = 1'b0, flush = 1'b0, hold = 1'b0;
  logic [1:0] de, m, wb;
  logic [3:0] ex;
  logic       vld_ex, vld_mem, vld_wb, ill;
  logic [7:0] cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  control_pipe dut (
    .clk(clk), .rst_n(rst_n), .opcode_i(opcode), .valid_i(valid_i),
    .stall_i(stall), .flush_i(flush), .hold_i(hold),
    .de_ctrl_o(de), .ex_ctrl_o(ex), .m_ctrl_o(m), .wb_ctrl_o(wb),
    .vld_ex_o(vld_ex), .vld_mem_o(vld_mem), .vld_wb_o(vld_wb),
    .illegal_o(ill), .illegal_cnt_o(cnt)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Instruction-level decode table {DE,EX,M,WB}; zero means illegal
  function automatic logic [9:0] dec(input logic [5:0] op);
    case (op)
      6'b100011: return 10'b00_0100_10_10;
      6'b101011: return 10'b00_0100_01_00;
      6'b000100: return 10'b11_0001_00_00;
      6'b000101: return 10'b10_0001_00_00;
      6'b000000: return 10'b00_1010_00_11;
      6'b001000, 6'b001100, 6'b001010, 6'b001101, 6'b001110:
                 return 10'b00_1110_00_11;
`ifdef CTRL_JUMP_EN
      6'b000010: return 10'b01_0000_00_00;
      6'b000011: return 10'b01_0000_00_10;
`endif
      default:   return 10'b0;
    endcase
  endfunction

  // Model: instruction tokens sitting in EX, MEM, WB
  logic       t_vld [3];
  logic [5:0] t_op  [3];
  logic       m_pend;
  logic       m_ill;
  int         m_cnt;
  logic [9:0] d_in;
  logic       m_bub;

  always_comb begin
    d_in  = dec(opcode);
    m_bub = stall | flush | m_pend | ~valid_i;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        t_vld[i] <= 1'b0;
        t_op[i]  <= '0;
      end
      m_pend <= 1'b0;
      m_ill  <= 1'b0;
      m_cnt  <= 0;
    end else if (!hold) begin
      t_vld[2] <= t_vld[1]; t_op[2] <= t_op[1];
      t_vld[1] <= t_vld[0]; t_op[1] <= t_op[0];
      t_vld[0] <= ~m_bub;   t_op[0] <= opcode;
      m_ill    <= ~m_bub && (d_in == 10'b0);
      if (~m_bub && (d_in == 10'b0) && m_cnt < 255) m_cnt <= m_cnt + 1;
      m_pend   <= 1'b0;
    end else begin
      if (flush) m_pend <= 1'b1;
      m_ill <= 1'b0;
    end
  end

  // Per-cycle comparison against the model, away from the active edge
  logic [9:0] e0, e1, e2;
  always @(negedge clk) begin
    e0 = t_vld[0] ? dec(t_op[0]) : 10'b0;
    e1 = t_vld[1] ? dec(t_op[1]) : 10'b0;
    e2 = t_vld[2] ? dec(t_op[2]) : 10'b0;
    chk("de",      de,      valid_i ? d_in[9:8] : 2'b00);
    chk("ex",      ex,      e0[7:4]);
    chk("m",       m,       e1[3:2]);
    chk("wb",      wb,      e2[1:0]);
    chk("vld_ex",  vld_ex,  t_vld[0]);
    chk("vld_mem", vld_mem, t_vld[1]);
    chk("vld_wb",  vld_wb,  t_vld[2]);
    chk("illegal", ill,     m_ill & ~hold);
    chk("cnt",     cnt,     m_cnt);
  end

  task automatic drv(input logic [5:0] op, input logic v, input logic s,
                     input logic f, input logic h);
    opcode = op; valid_i = v; stall = s; flush = f; hold = h;
    @(posedge clk);
    #2;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    // 1: async reset mid-stream, then R-type latency
    drv(6'b100011, 1, 0, 0, 0);
    drv(6'b000000, 1, 0, 0, 0);
    chk("t1_lw_in_mem", m, 2'b10);
    rst_n = 1'b0;
    #1;
    chk("t1_rst_ex",  ex, 4'b0);
    chk("t1_rst_m",   m, 2'b0);
    chk("t1_rst_wb",  wb, 2'b0);
    chk("t1_rst_vld", {vld_ex, vld_mem, vld_wb}, 3'b0);
    chk("t1_rst_cnt", {ill, cnt}, 9'b0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    drv(6'b000000, 1, 0, 0, 0);
    chk("t1_ex_r", ex, 4'b1010);
    drv(6'b000000, 0, 0, 0, 0);
    chk("t1_m_r", {vld_mem, m}, 3'b100);
    drv(6'b000000, 0, 0, 0, 0);
    chk("t1_wb_r", {vld_wb, wb}, 3'b111);

    // 2: LW, stall with ADDI in ID, ADDI again
    drv(6'b100011, 1, 0, 0, 0);
    chk("t2_ex0", ex, 4'b0100);
    drv(6'b001000, 1, 1, 0, 0);
    chk("t2_ex1", ex, 4'b0000);
    drv(6'b001000, 1, 0, 0, 0);
    chk("t2_ex2", ex, 4'b1110);

    // 3: BEQ decode is immediate; flushed SW becomes a bubble
    opcode = 6'b000100; valid_i = 1'b1;
    #1;
    chk("t3_de_beq", de, 2'b11);
    drv(6'b000100, 1, 0, 0, 0);
    drv(6'b101011, 1, 0, 1, 0);
    chk("t3_flush", {vld_ex, ex}, 5'b0);

    // 4: hold three cycles with flush in the first; first advance is a bubble
    drv(6'b100011, 1, 0, 0, 0);
    drv(6'b001000, 1, 0, 1, 1);
    chk("t4_hold1", {vld_ex, ex}, 5'b10100);
    drv(6'b001000, 1, 0, 0, 1);
    drv(6'b001000, 1, 0, 0, 1);
    chk("t4_hold3", {vld_ex, ex}, 5'b10100);
    drv(6'b001000, 1, 0, 0, 0);
    chk("t4_pend_bubble", {vld_ex, ex}, 5'b0);
    drv(6'b001000, 1, 0, 0, 0);
    chk("t4_after", {vld_ex, ex}, 5'b11110);

    // 5: 300 illegal opcodes, counter saturates
    for (int i = 0; i < 300; i++) begin
      drv(6'b111111, 1, 0, 0, 0);
      if (ill !== 1'b1) chk("t5_pulse", ill, 1'b1);
    end
    checks++;
    chk("t5_cnt_sat", cnt, 8'd255);
    drv(6'b000000, 0, 0, 0, 0);
    chk("t5_pulse_end", ill, 1'b0);

    // 6: jump opcode
    opcode = 6'b000010; valid_i = 1'b1;
    #1;
`ifdef CTRL_JUMP_EN
    chk("t6_de_j", de, 2'b01);
    drv(6'b000010, 1, 0, 0, 0);
    chk("t6_ill_j", ill, 1'b0);
`else
    chk("t6_de_j", de, 2'b00);
    drv(6'b000010, 1, 0, 0, 0);
    chk("t6_ill_j", ill, 1'b1);
`endif

    drv(6'b000000, 0, 0, 0, 0);
    drv(6'b000000, 0, 0, 0, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Watchdog so the run always ends
  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
